// File: rtl/bus_ram_pkg.sv
// Shared types and constants for the bus_ram block.
// Holds the controller state encoding, default geometry and the high-Z bus helper.
package bus_ram_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    // Replicate to DATA_WIDTH to build an undriven bus word.
    localparam logic Z_BIT = 1'bz;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

endpackage

// File: rtl/ram_array.sv
// Storage-only word array: one synchronous write port and one registered read port.
// The array has no reset. The parent only issues in-range addresses.
module ram_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [MEM_AW-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [MEM_AW-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register only updates on an accepted read, so it doubles as the hold buffer.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_ram.sv
// Parametrised RAM on the shared tri-state CPU data bus.
// Adds a sequential clear after reset, a side-band load port, handshakes and a sticky conflict flag.
module bus_ram
    import bus_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DEPTH          = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_enable,
    input  logic                  read_enable,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ready,
    output logic                  rd_valid,
    output logic                  conflict
);

    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH > (2 ** ADDR_WIDTH) || DEPTH == 0) begin : g_bad_depth
        $error("bus_ram: DEPTH must be between 1 and 2**ADDR_WIDTH");
    end

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] w_clr_ptr_next;
    logic                  r_rd_valid;
    logic                  r_conflict;
    logic                  r_buf_zero;

    logic                  w_run;
    logic                  w_ready;
    logic                  w_cpu_rd;
    logic                  w_cpu_wr;
    logic                  w_cpu_both;
    logic                  w_addr_ok;
    logic                  w_load_ok;
    logic                  w_mem_we;
    logic [MEM_AW-1:0]     w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_re;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic [DATA_WIDTH-1:0] w_buffer;

    assign w_run      = (r_state == RUN);
    assign w_ready    = w_run & ~load_enable;
    assign w_cpu_rd   = w_ready & read_enable & ~write_enable;
    assign w_cpu_wr   = w_ready & write_enable & ~read_enable;
    assign w_cpu_both = w_ready & write_enable & read_enable;
    assign w_addr_ok  = ({1'b0, address} < DEPTH_W);
    assign w_load_ok  = ({1'b0, load_address} < DEPTH_W);

    // Clear sequencer: walks clr_ptr up to the last word, then hands over to RUN.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        if (r_state == CLEAR) begin
            if (r_clr_ptr == LAST_PTR) begin
                w_state_next = RUN;
            end else begin
                w_clr_ptr_next = r_clr_ptr + 1'b1;
            end
        end
    end

    // Write-port priority: clear, then program load, then CPU. Out-of-range writes drop.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (rst) begin
            w_mem_we = 1'b0;
        end else if (!w_run) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_ptr[MEM_AW-1:0];
        end else if (load_enable) begin
            w_mem_we    = w_load_ok;
            w_mem_waddr = load_address[MEM_AW-1:0];
            w_mem_wdata = load_data;
        end else if (w_cpu_wr) begin
            w_mem_we    = w_addr_ok;
            w_mem_waddr = address[MEM_AW-1:0];
            w_mem_wdata = data;
        end
    end

    assign w_mem_re = ~rst & w_cpu_rd & w_addr_ok;

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram_array (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .i_raddr (address[MEM_AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_clr_ptr  <= '0;
            r_rd_valid <= 1'b0;
            r_conflict <= 1'b0;
            r_buf_zero <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_clr_ptr  <= w_clr_ptr_next;
            r_rd_valid <= w_cpu_rd;
            if (w_cpu_both) begin
                r_conflict <= 1'b1;
            end
            // The array read register is not reset; this flag makes the buffer read as zero
            // after reset and after an out-of-range read.
            if (w_cpu_rd) begin
                r_buf_zero <= ~w_addr_ok;
            end
        end
    end

    assign w_buffer = r_buf_zero ? '0 : w_mem_rdata;

    assign data     = w_cpu_rd ? w_buffer : {DATA_WIDTH{Z_BIT}};
    assign ready    = w_ready;
    assign rd_valid = r_rd_valid;
    assign conflict = r_conflict;

endmodule
